// File: rtl/recovery_request_arbiter.sv
// Collects one pending error event per detector and dispatches them one at a time to the recovery controller.
// Latency: src_valid -> pending next cycle -> error_detected the cycle after (when idle and enabled).
// Backpressure: one slot per source; a busy slot keeps the higher-severity report; dispatch waits for the controller and a cooldown gap.
module recovery_request_arbiter #(
  parameter int NUM_SRC       = 8,
  parameter int START_TIMEOUT = 16,
  parameter int MAX_REISSUE   = 2,
  parameter int GAP_CYCLES    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arb_enable,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*5-1:0]       src_type,
  input  logic [NUM_SRC*3-1:0]       src_severity,
  input  logic [NUM_SRC*32-1:0]      src_addr,
  input  logic [NUM_SRC-1:0]         src_recoverable,
  output logic                       error_detected,
  output logic [4:0]                 error_type,
  output logic [2:0]                 error_severity,
  output logic [31:0]                error_addr,
  output logic                       error_recoverable,
  input  logic                       recovery_active,
  input  logic                       recovery_failed,
  output logic [NUM_SRC-1:0]         pending,
  output logic                       busy,
  output logic [$clog2(NUM_SRC)-1:0] last_src,
  output logic                       last_failed,
  output logic [15:0]                dispatched_count,
  output logic [15:0]                coalesced_count,
  output logic [15:0]                abandoned_count,
  output logic [15:0]                failed_count
);

  localparam int              SW        = $clog2(NUM_SRC);
  localparam int              CW        = $clog2(NUM_SRC + 1);
  localparam logic [SW-1:0]   LAST_RST  = SW'(NUM_SRC - 1);
  localparam logic [15:0]     TO_LAST   = 16'(START_TIMEOUT - 1);
  localparam logic [15:0]     GAP_L     = 16'(GAP_CYCLES);
  localparam logic [7:0]      REISSUE_L = 8'(MAX_REISSUE);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_START, S_WAIT_DONE, S_COOLDOWN} state_t;

  state_t            state;
  logic [15:0]       timer;
  logic [7:0]        reissue;
  logic              fail_flag;

  logic [NUM_SRC-1:0] slot_vld;
  logic [4:0]         slot_type [NUM_SRC];
  logic [2:0]         slot_sev  [NUM_SRC];
  logic [31:0]        slot_addr [NUM_SRC];
  logic [NUM_SRC-1:0] slot_rec;

  logic [2:0]         max_sev;
  logic [SW-1:0]      win_idx;
  logic               win_found;
  logic [SW-1:0]      cidx;
  int                 cand;
  logic               dispatch;
  logic [CW-1:0]      coal_n;
  logic [16:0]        coal_sum;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign pending  = slot_vld;
  assign busy     = (state != S_IDLE);
  assign dispatch = (state == S_IDLE) && arb_enable && (|slot_vld);

  // Winner: highest stored severity, first match scanning round-robin from last_src+1.
  always_comb begin
    max_sev   = '0;
    win_idx   = last_src;
    win_found = 1'b0;
    cand      = 0;
    cidx      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (slot_vld[i] && slot_sev[i] > max_sev) max_sev = slot_sev[i];
    end
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = (int'(last_src) + k) % NUM_SRC;
      cidx = SW'(cand);
      if (!win_found && slot_vld[cidx] && slot_sev[cidx] == max_sev) begin
        win_found = 1'b1;
        win_idx   = cidx;
      end
    end
  end

  // Count reports that hit an occupied slot not being freed this cycle.
  always_comb begin
    coal_n = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i] && slot_vld[i] && !(dispatch && win_idx == SW'(i))) coal_n = coal_n + CW'(1);
    end
  end
  assign coal_sum = {1'b0, coalesced_count} + 17'(coal_n);

  // Slot capture/overwrite/clear; a slot freed by dispatch accepts a same-cycle report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld <= '0;
      slot_rec <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        slot_type[i] <= '0;
        slot_sev[i]  <= '0;
        slot_addr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid[i] && (!slot_vld[i] || (dispatch && win_idx == SW'(i)) ||
                             src_severity[3*i +: 3] > slot_sev[i])) begin
          slot_vld[i]  <= 1'b1;
          slot_type[i] <= src_type[5*i +: 5];
          slot_sev[i]  <= src_severity[3*i +: 3];
          slot_addr[i] <= src_addr[32*i +: 32];
          slot_rec[i]  <= src_recoverable[i];
        end else if (dispatch && win_idx == SW'(i)) begin
          slot_vld[i] <= 1'b0;
        end
      end
    end
  end

  // Saturating coalesce statistic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coalesced_count <= '0;
    else        coalesced_count <= coal_sum[16] ? 16'hFFFF : coal_sum[15:0];
  end

  // Dispatch FSM: latch winner, strobe, wait for start/done, then cooldown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      timer             <= '0;
      reissue           <= '0;
      fail_flag         <= 1'b0;
      error_detected    <= 1'b0;
      error_type        <= '0;
      error_severity    <= '0;
      error_addr        <= '0;
      error_recoverable <= 1'b0;
      last_src          <= LAST_RST;
      last_failed       <= 1'b0;
      dispatched_count  <= '0;
      abandoned_count   <= '0;
      failed_count      <= '0;
    end else begin
      error_detected <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dispatch) begin
            error_type        <= slot_type[win_idx];
            error_severity    <= slot_sev[win_idx];
            error_addr        <= slot_addr[win_idx];
            error_recoverable <= slot_rec[win_idx];
            last_src          <= win_idx;
            reissue           <= '0;
            dispatched_count  <= sat_inc(dispatched_count);
            error_detected    <= 1'b1;
            state             <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer <= '0;
          state <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (recovery_active) begin
            fail_flag <= 1'b0;
            state     <= S_WAIT_DONE;
          end else if (timer == TO_LAST) begin
            if (reissue < REISSUE_L) begin
              reissue        <= reissue + 8'd1;
              error_detected <= 1'b1;
              state          <= S_ISSUE;
            end else begin
              abandoned_count <= sat_inc(abandoned_count);
              timer           <= '0;
              state           <= S_COOLDOWN;
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_WAIT_DONE: begin
          if (recovery_failed) fail_flag <= 1'b1;
          if (!recovery_active) begin
            last_failed <= fail_flag | recovery_failed;
            if (fail_flag | recovery_failed) failed_count <= sat_inc(failed_count);
            timer <= '0;
            state <= S_COOLDOWN;
          end
        end
        S_COOLDOWN: begin
          timer <= timer + 16'd1;
          if ((timer + 16'd1) >= GAP_L) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_recovery_request_arbiter.sv
// Randomized scoreboard bench for recovery_request_arbiter.
// Expected dispatches come from a slot/priority model; a monitor checks each error_detected strobe.
// A responder plays the recovery controller according to per-event plans chosen by the model.
module tb_recovery_request_arbiter;
  localparam int N   = 8;
  localparam int TO  = 16;
  localparam int MR  = 2;
  localparam int GAP = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            arb_enable = 1'b0;
  logic [N-1:0]    src_valid = '0;
  logic [N*5-1:0]  src_type = '0;
  logic [N*3-1:0]  src_severity = '0;
  logic [N*32-1:0] src_addr = '0;
  logic [N-1:0]    src_recoverable = '0;
  logic            recovery_active = 1'b0;
  logic            recovery_failed = 1'b0;
  logic            error_detected;
  logic [4:0]      error_type;
  logic [2:0]      error_severity;
  logic [31:0]     error_addr;
  logic            error_recoverable;
  logic [N-1:0]    pending;
  logic            busy;
  logic [2:0]      last_src;
  logic            last_failed;
  logic [15:0]     dispatched_count, coalesced_count, abandoned_count, failed_count;

  recovery_request_arbiter #(.NUM_SRC(N), .START_TIMEOUT(TO), .MAX_REISSUE(MR), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .arb_enable(arb_enable), .src_valid(src_valid),
    .src_type(src_type), .src_severity(src_severity), .src_addr(src_addr),
    .src_recoverable(src_recoverable), .error_detected(error_detected),
    .error_type(error_type), .error_severity(error_severity), .error_addr(error_addr),
    .error_recoverable(error_recoverable), .recovery_active(recovery_active),
    .recovery_failed(recovery_failed), .pending(pending), .busy(busy), .last_src(last_src),
    .last_failed(last_failed), .dispatched_count(dispatched_count),
    .coalesced_count(coalesced_count), .abandoned_count(abandoned_count),
    .failed_count(failed_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          src;
    logic [4:0]  typ;
    logic [2:0]  sev;
    logic [31:0] addr;
    logic        rec;
    bit          ans;
    int          dly;
    int          len;
    bit          fail;
    int          fail_at;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   abort = 1'b0;
  bit   resp_running = 1'b0;

  // reference model state
  bit          m_vld [N];
  logic [4:0]  m_type [N];
  logic [2:0]  m_sev [N];
  logic [31:0] m_addr [N];
  bit          m_rec [N];
  int          m_last, m_disp, m_coal, m_aband, m_failed;
  bit          m_last_failed;

  // stimulus field staging
  logic [4:0]  f_type [N];
  logic [2:0]  f_sev [N];
  logic [31:0] f_addr [N];
  logic        f_rec [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
    m_last = N - 1;
    m_disp = 0; m_coal = 0; m_aband = 0; m_failed = 0;
    m_last_failed = 1'b0;
  endfunction

  function automatic void model_capture(int i);
    if (!m_vld[i]) begin
      m_vld[i] = 1'b1;
      m_type[i] = f_type[i]; m_sev[i] = f_sev[i]; m_addr[i] = f_addr[i]; m_rec[i] = f_rec[i];
    end else begin
      m_coal++;
      if (f_sev[i] > m_sev[i]) begin
        m_type[i] = f_type[i]; m_sev[i] = f_sev[i]; m_addr[i] = f_addr[i]; m_rec[i] = f_rec[i];
      end
    end
  endfunction

  function automatic void model_dispatch_one(bit ans, int dly, int len, bit fail, int fail_at);
    int   best = -1;
    exp_t e;
    for (int k = 1; k <= N; k++) begin
      int idx = (m_last + k) % N;
      if (m_vld[idx] && (best < 0 || m_sev[idx] > m_sev[best])) best = idx;
    end
    if (best < 0) return;
    e.src = best; e.typ = m_type[best]; e.sev = m_sev[best]; e.addr = m_addr[best];
    e.rec = m_rec[best]; e.ans = ans; e.dly = dly; e.len = len; e.fail = fail; e.fail_at = fail_at;
    sb.push_back(e);
    m_vld[best] = 1'b0;
    m_last = best;
    m_disp++;
    if (ans) begin
      m_last_failed = fail;
      if (fail) m_failed++;
    end else begin
      m_aband++;
    end
  endfunction

  function automatic void dispatch_rand();
    int len = int'($urandom_range(1, 6));
    bit fail = (len >= 2) && ($urandom_range(0, 2) == 0);
    int fa = (len >= 2) ? int'($urandom_range(1, len - 1)) : 0;
    model_dispatch_one($urandom_range(0, 4) != 0, int'($urandom_range(0, 10)), len, fail, fa);
  endfunction

  function automatic bit model_any();
    bit a = 1'b0;
    for (int i = 0; i < N; i++) a |= m_vld[i];
    return a;
  endfunction

  function automatic void dispatch_all_rand();
    while (model_any()) dispatch_rand();
  endfunction

  task automatic set_src(input int i, input logic [4:0] t, input logic [2:0] s,
                         input logic [31:0] a, input logic r);
    f_type[i] = t; f_sev[i] = s; f_addr[i] = a; f_rec[i] = r;
  endtask

  task automatic drive_src(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      src_type[5*i +: 5]   = f_type[i];
      src_severity[3*i +: 3] = f_sev[i];
      src_addr[32*i +: 32] = f_addr[i];
      src_recoverable[i]   = f_rec[i];
      if (v[i]) model_capture(i);
    end
    src_valid = v;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_err_fields"}, 64'({error_detected, error_type, error_severity, error_addr, error_recoverable}), 64'd0);
    chk({tag, "_counters"}, {dispatched_count, coalesced_count, abandoned_count, failed_count}, 64'd0);
    chk({tag, "_pending"}, 64'(pending), 64'd0);
    chk({tag, "_busy_lastfail"}, 64'({busy, last_failed}), 64'd0);
    chk({tag, "_last_src"}, 64'(last_src), 64'(N - 1));
  endtask

  task automatic check_state(input string tag);
    logic [N-1:0] mv;
    for (int i = 0; i < N; i++) mv[i] = m_vld[i];
    chk({tag, "_pending"}, 64'(pending), 64'(mv));
    chk({tag, "_dispatched"}, 64'(dispatched_count), 64'(m_disp));
    chk({tag, "_coalesced"}, 64'(coalesced_count), 64'(m_coal));
    chk({tag, "_abandoned"}, 64'(abandoned_count), 64'(m_aband));
    chk({tag, "_failed"}, 64'(failed_count), 64'(m_failed));
    chk({tag, "_last_src"}, 64'(last_src), 64'(m_last));
    chk({tag, "_last_failed"}, 64'(last_failed), 64'(m_last_failed));
  endtask

  task automatic drain(input string tag);
    int c = 0;
    while ((sb.size() != 0 || busy || resp_running) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_drain_timeout"}, 64'(c >= 3000), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Plays the recovery controller for one answered dispatch.
  task automatic respond(input exp_t e);
    resp_running = 1'b1;
    repeat (e.dly + 1) @(negedge clk);
    for (int j = 0; j < e.len && !abort; j++) begin
      recovery_active = 1'b1;
      recovery_failed = e.fail && (j == e.fail_at);
      @(negedge clk);
    end
    recovery_active = 1'b0;
    recovery_failed = 1'b0;
    resp_running = 1'b0;
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  initial begin : monitor
    exp_t        e;
    logic [43:0] expv;
    int          gap_hits;
    forever begin
      @(negedge clk);
      if (rst_n && error_detected) begin
        if (sb.size() == 0) begin
          chk("dispatch_without_expectation", 64'(error_detected), 64'd0);
        end else begin
          e = sb.pop_front();
          expv = {3'(e.src), e.typ, e.sev, e.addr, e.rec};
          chk("dispatch", 64'({last_src, error_type, error_severity, error_addr, error_recoverable}), 64'(expv));
          if (e.ans) begin
            fork
              respond(e);
            join_none
          end else begin
            for (int r = 1; r <= MR; r++) begin
              gap_hits = 0;
              repeat (TO) begin
                @(negedge clk);
                if (error_detected) gap_hits++;
              end
              @(negedge clk);
              chk("reissue_gap", 64'(gap_hits), 64'd0);
              chk("reissue_pulse", 64'({error_detected, last_src, error_type, error_severity, error_addr, error_recoverable}),
                  64'({1'b1, expv}));
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int bc, pc, w;
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) set_src(i, '0, '0, '0, 1'b0);
    model_reset();
    repeat (3) @(negedge clk);
    check_reset("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("after_reset");

    // single event: latency, fields, busy window
    set_src(3, 5'd6, 3'd2, 32'h1000, 1'b1);
    arb_enable = 1'b1;
    drive_src(8'h08);
    model_dispatch_one(1'b1, 0, 8, 1'b0, 0);
    @(negedge clk);
    src_valid = '0;
    chk("lat_pending_no_strobe", 64'({pending[3], error_detected}), 64'd2);
    @(negedge clk);
    chk("lat_strobe_slot_cleared", 64'({error_detected, pending[3]}), 64'd2);
    bc = 1;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      bc += int'(busy);
    end
    chk("single_busy_cycles", 64'(bc), 64'd14);
    drain("single");
    arb_enable = 1'b0;
    check_state("single");

    // severity priority with round-robin tie break from reset pointer
    apply_reset();
    set_src(0, 5'($urandom), 3'd1, $urandom, 1'($urandom));
    set_src(5, 5'($urandom), 3'd4, $urandom, 1'($urandom));
    set_src(6, 5'($urandom), 3'd4, $urandom, 1'($urandom));
    drive_src(8'h61);
    @(negedge clk);
    src_valid = '0;
    arb_enable = 1'b1;
    dispatch_all_rand();
    drain("priority");
    arb_enable = 1'b0;
    check_state("priority");

    // coalescing into slot 2
    set_src(2, 5'd1, 3'd1, 32'hA1, 1'b0); drive_src(8'h04); @(negedge clk); src_valid = '0;
    set_src(2, 5'd2, 3'd3, 32'hA2, 1'b1); drive_src(8'h04); @(negedge clk); src_valid = '0;
    set_src(2, 5'd3, 3'd2, 32'hA3, 1'b0); drive_src(8'h04); @(negedge clk); src_valid = '0;
    chk("coal_pending", 64'(pending), 64'h04);
    chk("coal_count", 64'(coalesced_count), 64'd2);
    arb_enable = 1'b1;
    dispatch_all_rand();
    drain("coalesce");
    arb_enable = 1'b0;
    check_state("coalesce");

    // no response: three strobes then abandon
    set_src(1, 5'd9, 3'd5, 32'hDEAD_0001, 1'b1);
    arb_enable = 1'b1;
    drive_src(8'h02);
    model_dispatch_one(1'b0, 0, 0, 1'b0, 0);
    @(negedge clk);
    src_valid = '0;
    drain("noresp");
    arb_enable = 1'b0;
    chk("noresp_abandoned", 64'(abandoned_count), 64'd1);
    check_state("noresp");

    // failure on last active cycle, plus capture in the dispatch cycle of slot 4
    set_src(4, 5'd17, 3'd6, 32'h4000_0040, 1'b0);
    drive_src(8'h10); @(negedge clk); src_valid = '0;
    arb_enable = 1'b1;
    model_dispatch_one(1'b1, 1, 4, 1'b1, 3);
    set_src(4, 5'd18, 3'd1, 32'h4000_0044, 1'b1);
    drive_src(8'h10);
    @(negedge clk);
    src_valid = '0;
    arb_enable = 1'b0;
    chk("same_cycle_capture_pending", 64'(pending[4]), 64'd1);
    drain("failpath");
    chk("failpath_last_failed", 64'(last_failed), 64'd1);
    chk("failpath_failed_count", 64'(failed_count), 64'd1);
    check_state("failpath");
    arb_enable = 1'b1;
    dispatch_all_rand();
    drain("failpath2");
    arb_enable = 1'b0;
    check_state("failpath2");

    // randomized rounds: load with dispatch held off, then release
    for (int r = 0; r < 6; r++) begin
      int ncyc = int'($urandom_range(2, 6));
      for (int c = 0; c < ncyc; c++) begin
        for (int i = 0; i < N; i++) set_src(i, 5'($urandom), 3'($urandom_range(0, 7)), $urandom, 1'($urandom));
        v = N'($urandom) & N'($urandom);
        drive_src(v);
        @(negedge clk);
        src_valid = '0;
      end
      arb_enable = 1'b1;
      dispatch_all_rand();
      drain("random");
      arb_enable = 1'b0;
      check_state("random");
    end

    // reset while the controller is mid-recovery with other slots pending
    for (int i = 0; i < N; i++) set_src(i, 5'($urandom), 3'($urandom_range(0, 7)), $urandom, 1'($urandom));
    drive_src(8'h86); @(negedge clk); src_valid = '0;
    arb_enable = 1'b1;
    model_dispatch_one(1'b1, 0, 40, 1'b0, 0);
    w = 0;
    while (!recovery_active && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("rst_test_active_seen", 64'(recovery_active), 64'd1);
    repeat (3) @(negedge clk);
    #2;
    abort = 1'b1;
    rst_n = 1'b0;
    recovery_active = 1'b0;
    recovery_failed = 1'b0;
    sb.delete();
    model_reset();
    #1;
    check_reset("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    pc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      pc += int'(error_detected);
    end
    chk("post_reset_strobes", 64'(pc), 64'd0);
    check_reset("post_reset");
    arb_enable = 1'b0;
    abort = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
